// File: rtl/bmp180_i2c_pkg.sv
// Shared constants for the BMP180 target emulation: register map, calibration
// ROM image and the bus FSM state type.
package bmp180_i2c_pkg;

    localparam logic [7:0] REG_CALIB_FIRST = 8'hAA;
    localparam logic [7:0] REG_CALIB_LAST  = 8'hBF;
    localparam logic [7:0] REG_ID          = 8'hD0;
    localparam logic [7:0] REG_SOFT_RESET  = 8'hE0;
    localparam logic [7:0] REG_CTRL_MEAS   = 8'hF4;
    localparam logic [7:0] REG_OUT_MSB     = 8'hF6;
    localparam logic [7:0] REG_OUT_LSB     = 8'hF7;
    localparam logic [7:0] REG_OUT_XLSB    = 8'hF8;

    localparam logic [7:0] SOFT_RESET_KEY = 8'hB6;

    localparam int CALIB_LEN = 22;

    // Datasheet example coefficients AC1..MD, big-endian words.
    localparam logic [7:0] CALIB_ROM [CALIB_LEN] = '{
        8'h01, 8'h98, 8'hFF, 8'hB8, 8'hC7, 8'hD1, 8'h7F, 8'hE5,
        8'h7F, 8'hF5, 8'h5A, 8'h71, 8'h18, 8'h2E, 8'h00, 8'h04,
        8'h80, 8'h00, 8'hDD, 8'hF9, 8'h0B, 8'h34
    };

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } stateT;

    function automatic logic [7:0] calibByte(input logic [7:0] adr);
        logic [4:0] idx;
        idx = 5'(adr - REG_CALIB_FIRST);
        return (int'(idx) < CALIB_LEN) ? CALIB_ROM[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchronizers with edge and START/STOP detection; both lines go
// through identical pipelines so their relative timing is preserved.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sclRise,
    output logic sclFall,
    output logic startDet,
    output logic stopDet,
    output logic sdaSync
);

    logic [SYNC_STAGES-1:0] sclPipe;
    logic [SYNC_STAGES-1:0] sdaPipe;
    logic                   sclPrev;
    logic                   sdaPrev;
    logic                   sclNow;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclPipe <= '1;
            sdaPipe <= '1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPipe <= {sclPipe[SYNC_STAGES-2:0], scl};
            sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], sda};
            sclPrev <= sclPipe[SYNC_STAGES-1];
            sdaPrev <= sdaPipe[SYNC_STAGES-1];
        end
    end

    assign sclNow   = sclPipe[SYNC_STAGES-1];
    assign sdaSync  = sdaPipe[SYNC_STAGES-1];
    assign sclRise  = sclNow & ~sclPrev;
    assign sclFall  = ~sclNow & sclPrev;
    assign startDet = sclNow & sclPrev & sdaPrev & ~sdaSync;
    assign stopDet  = sclNow & sclPrev & ~sdaPrev & sdaSync;

endmodule

// File: rtl/bmp180_i2c_target.sv
// I2C target emulating a BMP180: address match, register pointer with
// auto-increment, ID / calibration / control / measurement registers.
//
//   state        | meaning
//   IDLE         | bus free, waiting for START
//   ADDR         | shifting address byte
//   ADDR_ACK     | acknowledging our address
//   REG          | shifting register pointer
//   REG_ACK      | acknowledging pointer
//   WDATA        | shifting write data
//   WDATA_ACK    | acknowledging data, commit at its end
//   RDATA        | driving read data
//   RDATA_ACK    | sampling master ACK/NACK
//   IGNORE       | not addressed or read ended, wait for START/STOP
module bmp180_i2c_target
    import bmp180_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADR     = 7'h77,
    parameter logic [7:0] CHIP_ID     = 8'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [23:0] meas_data,
    output logic [7:0]  ctrl_meas,
    output logic        meas_start,
    output logic        busy
);

    logic sclRise, sclFall, startDet, stopDet, sdaSync;

    i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) busCond (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl_i),
        .sda      (sda_i),
        .sclRise  (sclRise),
        .sclFall  (sclFall),
        .startDet (startDet),
        .stopDet  (stopDet),
        .sdaSync  (sdaSync)
    );

    stateT       state, stateNext;
    logic [3:0]  bitCnt, cntNext;
    logic [7:0]  shiftReg, pointer, txShift, ctrlMeasR, rdByte;
    logic [23:0] snapshot;
    logic        rwBit, sdaOeR, sdaOeNext, busyR, measStartR;
    logic        shiftIn, setBusy, takeSnap, loadPtr, writeReg, loadTx, shiftTx;
    logic        byteDone, ackEnd, adrMatch;

    assign byteDone = sclRise && (bitCnt == 4'd7);
    assign ackEnd   = sclFall && (bitCnt == 4'd9);
    assign adrMatch = ({shiftReg[6:0], sdaSync} >> 1) == {1'b0, DEV_ADR};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (stopDet) begin
            stateNext = ST_IDLE;
        end else if (startDet) begin
            stateNext = ST_ADDR;
        end else begin
            unique case (state)
                ST_ADDR:      if (byteDone) stateNext = adrMatch ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:  if (ackEnd) stateNext = rwBit ? ST_RDATA : ST_REG;
                ST_REG:       if (byteDone) stateNext = ST_REG_ACK;
                ST_REG_ACK:   if (ackEnd) stateNext = ST_WDATA;
                ST_WDATA:     if (byteDone) stateNext = ST_WDATA_ACK;
                ST_WDATA_ACK: if (ackEnd) stateNext = ST_WDATA;
                ST_RDATA:     if (byteDone) stateNext = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (sclRise && sdaSync) stateNext = ST_IGNORE;
                    else if (ackEnd) stateNext = ST_RDATA;
                end
                default:      stateNext = state;
            endcase
        end
    end

    // Every ACK-type state runs the same 9th-bit window: drive (or release)
    // at bitCnt 8's falling edge, exit at bitCnt 9's falling edge.
    always_comb begin
        sdaOeNext = sdaOeR;
        cntNext   = bitCnt;
        shiftIn   = 1'b0;
        setBusy   = 1'b0;
        takeSnap  = 1'b0;
        loadPtr   = 1'b0;
        writeReg  = 1'b0;
        loadTx    = 1'b0;
        shiftTx   = 1'b0;
        if (stopDet || startDet) begin
            sdaOeNext = 1'b0;
            cntNext   = 4'd0;
        end else begin
            unique case (state)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (sclRise) begin
                        shiftIn = 1'b1;
                        cntNext = bitCnt + 4'd1;
                        if (state == ST_ADDR && bitCnt == 4'd7 && adrMatch) begin
                            setBusy  = 1'b1;
                            takeSnap = sdaSync;
                        end
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK, ST_RDATA_ACK: begin
                    if (sclRise) begin
                        cntNext = 4'd9;
                    end else if (sclFall && bitCnt == 4'd8) begin
                        sdaOeNext = (state != ST_RDATA_ACK);
                    end else if (ackEnd) begin
                        cntNext   = 4'd0;
                        sdaOeNext = 1'b0;
                        loadPtr   = (state == ST_REG_ACK);
                        writeReg  = (state == ST_WDATA_ACK);
                        if ((state == ST_ADDR_ACK && rwBit) || state == ST_RDATA_ACK) begin
                            loadTx    = 1'b1;
                            sdaOeNext = ~rdByte[7];
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclRise) begin
                        cntNext = bitCnt + 4'd1;
                    end else if (sclFall) begin
                        shiftTx   = 1'b1;
                        sdaOeNext = ~txShift[6];
                    end
                end
                default: begin
                    cntNext   = 4'd0;
                    sdaOeNext = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdByte = 8'h00;
        if (pointer >= REG_CALIB_FIRST && pointer <= REG_CALIB_LAST) begin
            rdByte = calibByte(pointer);
        end else begin
            case (pointer)
                REG_ID:        rdByte = CHIP_ID;
                REG_CTRL_MEAS: rdByte = ctrlMeasR;
                REG_OUT_MSB:   rdByte = snapshot[23:16];
                REG_OUT_LSB:   rdByte = snapshot[15:8];
                REG_OUT_XLSB:  rdByte = snapshot[7:0];
                default:       rdByte = 8'h00;
            endcase
        end
    end

    // Pointer advances once per byte written or loaded for transmit.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitCnt     <= '0;
            shiftReg   <= '0;
            pointer    <= '0;
            txShift    <= '0;
            ctrlMeasR  <= '0;
            snapshot   <= '0;
            rwBit      <= 1'b0;
            sdaOeR     <= 1'b0;
            busyR      <= 1'b0;
            measStartR <= 1'b0;
        end else begin
            bitCnt     <= cntNext;
            sdaOeR     <= sdaOeNext;
            measStartR <= 1'b0;
            if (shiftIn) shiftReg <= {shiftReg[6:0], sdaSync};
            if (shiftIn && state == ST_ADDR && bitCnt == 4'd7) rwBit <= sdaSync;
            if (setBusy) busyR <= 1'b1;
            else if (stopDet) busyR <= 1'b0;
            if (takeSnap) snapshot <= meas_data;
            if (loadPtr) pointer <= shiftReg;
            else if (writeReg || loadTx) pointer <= pointer + 8'd1;
            if (loadTx) txShift <= rdByte;
            else if (shiftTx) txShift <= {txShift[6:0], 1'b0};
            if (writeReg) begin
                if (pointer == REG_CTRL_MEAS) begin
                    ctrlMeasR  <= shiftReg;
                    measStartR <= 1'b1;
                end else if (pointer == REG_SOFT_RESET && shiftReg == SOFT_RESET_KEY) begin
                    ctrlMeasR <= '0;
                end
            end
        end
    end

    assign sda_oe     = sdaOeR;
    assign ctrl_meas  = ctrlMeasR;
    assign meas_start = measStartR;
    assign busy       = busyR;

endmodule

// File: tb/tb_bmp180_i2c_target.sv
// Bench for bmp180_i2c_target: a bit-banged I2C master with a scoreboard of
// expected ACKs and read bytes, plus a register-level reference model.
module tb_bmp180_i2c_target;
    import bmp180_i2c_pkg::*;

    localparam int Q = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclM = 1'b1;
    logic        sdaM = 1'b1;
    logic        sdaLine;
    logic        sda_oe, meas_start, busy;
    logic [23:0] meas_data = 24'h0;
    logic [7:0]  ctrl_meas;

    assign sdaLine = sdaM & ~sda_oe;

    bmp180_i2c_target dut (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (sclM),
        .sda_i      (sdaLine),
        .sda_oe     (sda_oe),
        .meas_data  (meas_data),
        .ctrl_meas  (ctrl_meas),
        .meas_start (meas_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } expT;
    expT         expQ[$];
    event        obsEv;
    int          obsKind;
    logic [7:0]  obsVal;

    // Reference model state
    logic [7:0]  mPtr = 8'h00;
    logic [7:0]  mCtrl = 8'h00;
    logic [23:0] mSnap = 24'h0;
    int          expPulses = 0;
    int          measPulses = 0;
    logic        watchOe = 1'b0;
    logic        oeSeen = 1'b0;
    logic [7:0]  wrBuf[$];

    localparam logic [15:0] CAL_WORDS [11] = '{
        16'd408, 16'hFFB8, 16'hC7D1, 16'd32741, 16'd32757, 16'd23153,
        16'd6190, 16'd4, 16'h8000, 16'hDDF9, 16'd2868
    };

    function automatic logic [7:0] modelRead(input logic [7:0] a);
        int off;
        logic [15:0] w;
        if (a >= 8'hAA && a <= 8'hBF) begin
            off = int'(a) - 'hAA;
            w = CAL_WORDS[off / 2];
            return (off % 2 == 0) ? w[15:8] : w[7:0];
        end
        case (a)
            8'hD0:   return 8'h55;
            8'hF4:   return mCtrl;
            8'hF6:   return mSnap[23:16];
            8'hF7:   return mSnap[15:8];
            8'hF8:   return mSnap[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelWrite(input logic [7:0] a, input logic [7:0] v);
        if (a == 8'hF4) begin
            mCtrl = v;
            expPulses++;
        end else if (a == 8'hE0 && v == 8'hB6) begin
            mCtrl = 8'h00;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (meas_start) measPulses <= measPulses + 1;
        if (watchOe && sda_oe) oeSeen <= 1'b1;
    end

    initial begin
        expT e;
        forever begin
            @(obsEv);
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow actual=%0h required=none", obsVal);
            end else begin
                e = expQ.pop_front();
                if (e.kind != obsKind || e.val !== obsVal) begin
                    failures++;
                    $display("FAIL %s actual=%0h required=%0h",
                             (e.kind == 0) ? "ack" : "rdata", obsVal, e.val);
                end
            end
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic bitCycle(input logic b, output logic s);
        sdaM = b;
        #(Q); sclM = 1'b1;
        #(Q); s = sdaLine;
        #(Q); sclM = 1'b0;
        #(Q);
    endtask

    task automatic startCond();
        sdaM = 1'b1;
        #(Q); sclM = 1'b1;
        #(Q); sdaM = 1'b0;
        #(Q); sclM = 1'b0;
        #(Q);
    endtask

    task automatic stopCond();
        sdaM = 1'b0;
        #(Q); sclM = 1'b1;
        #(Q); sdaM = 1'b1;
        #(4 * Q);
    endtask

    task automatic writeByte(input logic [7:0] b, input logic expAck);
        logic s;
        expQ.push_back('{0, {7'd0, expAck}});
        for (int i = 7; i >= 0; i--) bitCycle(b[i], s);
        bitCycle(1'b1, s);
        obsKind = 0;
        obsVal  = {7'd0, s};
        ->obsEv;
    endtask

    task automatic readByte(input logic [7:0] expByte, input logic nack);
        logic s;
        logic [7:0] v;
        expQ.push_back('{1, expByte});
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bitCycle(1'b1, s);
            v = {v[6:0], s};
        end
        bitCycle(nack, s);
        obsKind = 1;
        obsVal  = v;
        ->obsEv;
    endtask

    task automatic txWrite(input logic [7:0] ptr);
        startCond();
        writeByte(8'hEE, 1'b0);
        writeByte(ptr, 1'b0);
        mPtr = ptr;
        foreach (wrBuf[i]) begin
            writeByte(wrBuf[i], 1'b0);
            modelWrite(mPtr, wrBuf[i]);
            mPtr = mPtr + 8'd1;
        end
        stopCond();
        check("wr_busy_after_stop", busy, 0);
        check("wr_ctrl_meas", ctrl_meas, mCtrl);
        check("wr_meas_pulses", measPulses, expPulses);
    endtask

    task automatic txRead(input logic setPtr, input logic [7:0] ptr, input int n, input logic changeMeas);
        startCond();
        if (setPtr) begin
            writeByte(8'hEE, 1'b0);
            writeByte(ptr, 1'b0);
            mPtr = ptr;
            startCond();
        end
        writeByte(8'hEF, 1'b0);
        mSnap = meas_data;
        for (int i = 0; i < n; i++) begin
            readByte(modelRead(mPtr), (i == n - 1));
            mPtr = mPtr + 8'd1;
            if (changeMeas && i == 0) meas_data = 24'($urandom);
        end
        check("rd_busy_before_stop", busy, 1);
        stopCond();
        check("rd_busy_after_stop", busy, 0);
    endtask

    initial begin
        logic s;
        logic [7:0] p;
        int n;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl_meas", ctrl_meas, 0);
        check("rst_meas_start", meas_start, 0);
        reset = 1'b0;
        #(4 * Q);

        // ID read
        txRead(1'b1, 8'hD0, 1, 1'b0);

        // Calibration burst, then pointer must sit one past the ROM
        txRead(1'b1, 8'hAA, 22, 1'b0);
        check("calib_no_drive_after_nack", sda_oe, 0);
        txRead(1'b0, 8'h00, 1, 1'b0);

        // Measurement start and stable snapshot
        wrBuf = '{8'h2E};
        txWrite(8'hF4);
        check("meas_ctrl_2e", ctrl_meas, 8'h2E);
        meas_data = 24'h5A3C10;
        txRead(1'b1, 8'hF6, 3, 1'b1);

        // Wrong address
        p = ctrl_meas;
        watchOe = 1'b1;
        oeSeen  = 1'b0;
        startCond();
        writeByte(8'hA0, 1'b1);
        check("wrong_busy", busy, 0);
        stopCond();
        #(Q);
        watchOe = 1'b0;
        check("wrong_no_drive", oeSeen, 0);
        check("wrong_ctrl_unchanged", ctrl_meas, p);

        // Abort inside a data byte
        startCond();
        writeByte(8'hEE, 1'b0);
        writeByte(8'hF4, 1'b0);
        mPtr = 8'hF4;
        for (int i = 0; i < 4; i++) bitCycle(1'($urandom), s);
        stopCond();
        check("abort_ctrl", ctrl_meas, mCtrl);
        check("abort_pulses", measPulses, expPulses);
        wrBuf = '{8'($urandom) | 8'h01};
        txWrite(8'hF4);
        wrBuf = '{8'h12};
        txWrite(8'hE0);
        wrBuf = '{8'hB6};
        txWrite(8'hE0);
        check("soft_reset_ctrl", ctrl_meas, 8'h00);

        // Randomized mix
        for (int it = 0; it < 8; it++) begin
            meas_data = 24'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    wrBuf = '{8'($urandom)};
                    txWrite(8'hF4);
                    txRead(1'b1, 8'hF4, 1, 1'b0);
                end
                1: begin
                    p = 8'($urandom);
                    n = $urandom_range(1, 4);
                    txRead(1'b1, p, n, 1'b1);
                end
                2: begin
                    p = 8'($urandom);
                    n = $urandom_range(1, 3);
                    wrBuf = {};
                    for (int k = 0; k < n; k++) wrBuf.push_back(8'($urandom));
                    txWrite(p);
                    txRead(1'b0, 8'h00, 1, 1'b0);
                end
                default: begin
                    txRead(1'b1, 8'hF6, 3, 1'b1);
                end
            endcase
        end

        // Reset while driving a 0 data bit (first calibration byte is 0x01)
        startCond();
        writeByte(8'hEE, 1'b0);
        writeByte(8'hAA, 1'b0);
        startCond();
        writeByte(8'hEF, 1'b0);
        #20;
        check("rdrive_oe_before_reset", sda_oe, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_sda_oe", sda_oe, 0);
        check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        check("midrst_pointer", dut.pointer, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        mPtr  = 8'h00;
        mCtrl = 8'h00;
        sdaM  = 1'b1;
        #(Q);
        sclM = 1'b1;
        #(4 * Q);
        check("midrst_busy", busy, 0);
        check("midrst_ctrl", ctrl_meas, 0);
        txRead(1'b0, 8'h00, 1, 1'b0);

        #(10 * Q);
        check("scoreboard_drained", expQ.size(), 0);
        check("final_pulses", measPulses, expPulses);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
